uart_frame_accumulator: RTL and testbench

UART_FRAME_ACCUMULATOR -- requirements
Module: uart_frame_accumulator

---
 rtl/uart_frame_accumulator.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_frame_accumulator.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_accumulator.sv
// uart_frame_accumulator
//
// Collects FRAME_LEN received words into one accumulator and sends the result
// back out as ACC_WIDTH/DATA_WIDTH words, least significant word first.
// The operation is chosen per frame by i_mode on the first accepted word:
// 0 = SUM (modulo 2^ACC_WIDTH), 1 = XOR, 2 = MAX, 3 = MIN (unsigned).
// A frame is abandoned if the gap between words reaches TIMEOUT_CYCLES.
//
// Ports
//   i_clk        clock, all flops on the rising edge
//   i_reset      asynchronous active-high reset
//   i_mode       operation select, sampled on the first word of a frame
//   i_rx_data    received word
//   i_rx_valid   i_rx_data valid this cycle
//   o_rx_ready   block can accept a word (IDLE or COLLECT, not in reset)
//   o_tx_data    current result word (zero when not sending)
//   o_tx_valid   o_tx_data valid (SEND state)
//   i_tx_ready   transmitter takes o_tx_data this cycle
//   o_frame_done pulse after the final result word was taken
//   o_frame_err  pulse after a frame was aborted by timeout
//   o_overflow   SUM of the last completed frame wrapped
//   o_drop       pulse for a valid word that arrived while busy sending
module uart_frame_accumulator #(
    parameter int DATA_WIDTH     = 8,
    parameter int FRAME_LEN      = 16,
    parameter int ACC_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [1:0]            i_mode,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_frame_done,
    output logic                  o_frame_err,
    output logic                  o_overflow,
    output logic                  o_drop
);

    localparam int NUM_WORDS = ACC_WIDTH / DATA_WIDTH;
    localparam int CNT_W     = (FRAME_LEN > 0) ? $clog2(FRAME_LEN + 1) : 1;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int GAP_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_WORDS - 1);
    localparam logic [GAP_W-1:0] TIMEOUT_C   = GAP_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] MODE_SUM = 2'd0;
    localparam logic [1:0] MODE_XOR = 2'd1;
    localparam logic [1:0] MODE_MAX = 2'd2;
    localparam logic [1:0] MODE_MIN = 2'd3;

    generate
        if (((ACC_WIDTH % DATA_WIDTH) != 0) || (ACC_WIDTH < DATA_WIDTH)) begin : g_bad_acc_width
            $error("ACC_WIDTH must be a non-zero multiple of DATA_WIDTH");
        end
        if (FRAME_LEN < 1) begin : g_bad_frame_len
            $error("FRAME_LEN must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SEND    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  drop_q, drop_d;
    logic                  overflow_q, overflow_d;

    logic                  rx_ready_s;
    logic                  accept_s;
    logic [ACC_WIDTH-1:0]  word_ext_s;
    logic [ACC_WIDTH:0]    sum_s;
    logic [GAP_W-1:0]      gap_inc_s;
    logic [DATA_WIDTH-1:0] tx_word_s;

    // Ready is forced low while reset is held so nothing is accepted then.
    assign rx_ready_s = ((state_q == ST_IDLE) || (state_q == ST_COLLECT)) && !i_reset;
    assign accept_s   = i_rx_valid && rx_ready_s;
    assign word_ext_s = ACC_WIDTH'(i_rx_data);
    // The extra top bit of sum_s is the carry out of the accumulator.
    assign sum_s      = {1'b0, acc_q} + {1'b0, word_ext_s};
    assign gap_inc_s  = gap_q + GAP_W'(1);

    // Select the result word currently being offered to the transmitter.
    always_comb begin
        tx_word_s = {DATA_WIDTH{1'b0}};
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (idx_q == IDX_W'(w)) begin
                tx_word_s = acc_q[w*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                tx_word_s = tx_word_s;
            end
        end
    end

    // Next-state, accumulator update and pulse generation.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        drop_d     = 1'b0;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    mode_d  = i_mode;
                    acc_d   = word_ext_s;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(1);
                    gap_d   = {GAP_W{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    state_d = (FRAME_LEN == 1) ? ST_SEND : ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_COLLECT: begin
                if (accept_s) begin
                    case (mode_q)
                        MODE_SUM: begin
                            acc_d = sum_s[ACC_WIDTH-1:0];
                            ovf_d = ovf_q | sum_s[ACC_WIDTH];
                        end
                        MODE_XOR: acc_d = acc_q ^ word_ext_s;
                        MODE_MAX: acc_d = (word_ext_s > acc_q) ? word_ext_s : acc_q;
                        MODE_MIN: acc_d = (word_ext_s < acc_q) ? word_ext_s : acc_q;
                        default:  acc_d = acc_q;
                    endcase
                    cnt_d = cnt_q + CNT_W'(1);
                    gap_d = {GAP_W{1'b0}};
                    if ((cnt_q + CNT_W'(1)) == FRAME_LEN_C) begin
                        state_d = ST_SEND;
                        idx_d   = {IDX_W{1'b0}};
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else if (TIMEOUT_CYCLES > 0) begin
                    // Accept takes priority; only an idle cycle can time out.
                    if (gap_inc_s == TIMEOUT_C) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                        acc_d   = {ACC_WIDTH{1'b0}};
                        ovf_d   = 1'b0;
                        cnt_d   = {CNT_W{1'b0}};
                        gap_d   = {GAP_W{1'b0}};
                    end else begin
                        gap_d = gap_inc_s;
                    end
                end else begin
                    gap_d = {GAP_W{1'b0}};
                end
            end

            ST_SEND: begin
                drop_d = i_rx_valid;
                if (i_tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = ST_IDLE;
                        done_d     = 1'b1;
                        overflow_d = ovf_q;
                        idx_d      = {IDX_W{1'b0}};
                        cnt_d      = {CNT_W{1'b0}};
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= 2'd0;
            acc_q      <= {ACC_WIDTH{1'b0}};
            ovf_q      <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            gap_q      <= {GAP_W{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_rx_ready   = rx_ready_s;
    assign o_tx_valid   = (state_q == ST_SEND);
    assign o_tx_data    = (state_q == ST_SEND) ? tx_word_s : {DATA_WIDTH{1'b0}};
    assign o_frame_done = done_q;
    assign o_frame_err  = err_q;
    assign o_overflow   = overflow_q;
    assign o_drop       = drop_q;

endmodule

// File: tb/tb_uart_frame_accumulator.sv
// Bench for uart_frame_accumulator: directed scenarios with literal results
// plus randomized traffic checked every cycle against a frame-level model.
module tb_uart_frame_accumulator;

    localparam int DW = 8;
    localparam int FL = 4;
    localparam int AW = 16;
    localparam int TO = 8;
    localparam int NW = AW / DW;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [7:0] rxd;
    logic       rxv;
    logic       txr;

    logic       ready, txv, done, err, ovf, drop;
    logic [7:0] txd;
    logic       ready8, txv8, done8, err8, ovf8, drop8;
    logic [7:0] txd8;

    int n_cmp = 0;
    int n_bad = 0;

    uart_frame_accumulator #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .ACC_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_rx_data(rxd), .i_rx_valid(rxv),
        .o_rx_ready(ready), .o_tx_data(txd), .o_tx_valid(txv), .i_tx_ready(txr),
        .o_frame_done(done), .o_frame_err(err), .o_overflow(ovf), .o_drop(drop));

    uart_frame_accumulator #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .ACC_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut8 (
        .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_rx_data(rxd), .i_rx_valid(rxv),
        .o_rx_ready(ready8), .o_tx_data(txd8), .o_tx_valid(txv8), .i_tx_ready(txr),
        .o_frame_done(done8), .o_frame_err(err8), .o_overflow(ovf8), .o_drop(drop8));

    always #5 clk = ~clk;

    // Frame-level model state
    logic [7:0]  m_q[$];
    logic [1:0]  m_mode = 2'd0;
    int          m_gap = 0;
    bit          m_send = 1'b0;
    int          m_idx = 0;
    logic [15:0] m_res = 16'h0000;
    bit          m_fovf = 1'b0;

    // Expected DUT outputs
    bit         e_ready = 1'b0, e_valid = 1'b0, e_done = 1'b0, e_err = 1'b0;
    bit         e_drop = 1'b0, e_ovf = 1'b0;
    logic [7:0] e_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_outs();
        e_ready = !rst && !m_send;
        e_valid = m_send;
        e_data  = m_send ? m_res[m_idx*8 +: 8] : 8'h00;
    endtask

    task automatic model_clear();
        m_q.delete();
        m_gap  = 0;
        m_send = 1'b0;
        m_idx  = 0;
        m_res  = 16'h0000;
        m_fovf = 1'b0;
        e_ovf  = 1'b0;
        e_done = 1'b0;
        e_err  = 1'b0;
        e_drop = 1'b0;
        model_outs();
    endtask

    // Result of a whole frame from plain arithmetic over the received words.
    task automatic frame_result();
        int unsigned tot = 0, x = 0, mx = 0, mn = 255;
        foreach (m_q[i]) begin
            tot += m_q[i];
            x   ^= m_q[i];
            if (m_q[i] > mx) mx = m_q[i];
            if (m_q[i] < mn) mn = m_q[i];
        end
        m_fovf = 1'b0;
        case (m_mode)
            2'd0: begin m_res = tot[15:0]; m_fovf = (tot > 32'd65535); end
            2'd1: m_res = x[15:0];
            2'd2: m_res = mx[15:0];
            default: m_res = mn[15:0];
        endcase
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input logic [1:0] md, input bit tr);
        e_done = 1'b0; e_err = 1'b0; e_drop = 1'b0;
        if (rst) begin
            model_clear();
            return;
        end
        if (m_send) begin
            if (v) e_drop = 1'b1;
            if (tr) begin
                m_idx++;
                if (m_idx == NW) begin
                    m_send = 1'b0; m_idx = 0; e_done = 1'b1; e_ovf = m_fovf;
                end
            end
        end else if (v) begin
            if (m_q.size() == 0) m_mode = md;
            m_q.push_back(d);
            m_gap = 0;
            if (m_q.size() == FL) begin
                frame_result();
                m_q.delete();
                m_send = 1'b1;
                m_idx  = 0;
            end
        end else if (m_q.size() > 0) begin
            m_gap++;
            if (m_gap == TO) begin
                m_q.delete(); m_gap = 0; e_err = 1'b1;
            end
        end
        model_outs();
    endtask

    task automatic cycle(input bit v, input logic [7:0] d, input logic [1:0] md, input bit tr);
        rxv = v; rxd = d; mode = md; txr = tr;
        @(posedge clk); #1;
        model_step(v, d, md, tr);
    endtask

    task automatic set_reset(input bit r);
        rst = r;
        if (r) model_clear();
        else   model_outs();
    endtask

    task automatic send4(input logic [1:0] md, input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [7:0] w3, input bit tr);
        cycle(1'b1, w0, md, tr);
        cycle(1'b1, w1, ~md, tr);
        cycle(1'b1, w2, md ^ 2'd2, tr);
        cycle(1'b1, w3, ~md, tr);
    endtask

    // Every-cycle comparison of the main DUT against the model.
    always @(negedge clk) begin
        chk("rx_ready", ready, e_ready);
        chk("tx_valid", txv, e_valid);
        chk("tx_data", txd, e_data);
        chk("frame_done", done, e_done);
        chk("frame_err", err, e_err);
        chk("drop", drop, e_drop);
        chk("overflow", ovf, e_ovf);
    end

    initial begin
        logic [7:0] mode_exp [3];
        int drops;
        int pct;
        mode_exp[0] = 8'hC2; mode_exp[1] = 8'hF0; mode_exp[2] = 8'h01;

        rst = 1'b1; rxv = 1'b0; rxd = 8'h00; mode = 2'd0; txr = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", ready, 1'b0);
        chk("reset_txv", txv, 1'b0);
        chk("reset_txd", txd, 8'h00);
        chk("reset_ovf", ovf, 1'b0);
        set_reset(1'b0);
        #1 chk("ready_after_reset", ready, 1'b1);

        // SUM 0x10+0x20+0x30+0x40, later words carry other modes that must be ignored
        send4(2'd0, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
        chk("sum_lo", txd, 8'hA0);
        chk("sum_lo_valid", txv, 1'b1);
        cycle(1'b0, 8'h00, 2'd0, 1'b1);
        chk("sum_hi", txd, 8'h00);
        cycle(1'b0, 8'h00, 2'd0, 1'b1);
        chk("sum_done", done, 1'b1);
        chk("sum_ovf", ovf, 1'b0);

        // XOR / MAX / MIN over the same words
        for (int m = 1; m < 4; m++) begin
            send4(2'(m), 8'h0F, 8'hF0, 8'h3C, 8'h01, 1'b1);
            chk("mode_lo", txd, mode_exp[m-1]);
            cycle(1'b0, 8'h00, 2'd0, 1'b1);
            chk("mode_hi", txd, 8'h00);
            cycle(1'b0, 8'h00, 2'd0, 1'b1);
            chk("mode_done", done, 1'b1);
        end

        // Back-pressure with drops in SEND
        send4(2'd0, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
        drops = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'b0);
            chk("stall_data", txd, 8'h0A);
            chk("stall_ready", ready, 1'b0);
            drops += int'(drop);
        end
        chk("drop_count", drops, 5);
        cycle(1'b0, 8'h00, 2'd0, 1'b1);
        chk("stall_hi", txd, 8'h00);
        cycle(1'b0, 8'h00, 2'd0, 1'b1);

        // Timeout after two words, then a clean frame
        cycle(1'b1, 8'h55, 2'd0, 1'b1);
        cycle(1'b1, 8'h66, 2'd0, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 2'd0, 1'b1);
        chk("no_err_yet", err, 1'b0);
        cycle(1'b0, 8'h00, 2'd0, 1'b1);
        chk("timeout_err", err, 1'b1);
        send4(2'd0, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
        chk("after_timeout_sum", txd, 8'h0A);
        cycle(1'b0, 8'h00, 2'd0, 1'b1);
        cycle(1'b0, 8'h00, 2'd0, 1'b1);

        // Narrow accumulator: 4 x 0x80 wraps to 0x00 with overflow
        set_reset(1'b1);
        cycle(1'b0, 8'h00, 2'd0, 1'b0);
        set_reset(1'b0);
        send4(2'd0, 8'h80, 8'h80, 8'h80, 8'h80, 1'b1);
        chk("acc8_valid", txv8, 1'b1);
        chk("acc8_data", txd8, 8'h00);
        chk("acc16_lo", txd, 8'h00);
        cycle(1'b0, 8'h00, 2'd0, 1'b1);
        chk("acc8_done", done8, 1'b1);
        chk("acc8_ovf", ovf8, 1'b1);
        chk("acc16_hi", txd, 8'h02);
        cycle(1'b0, 8'h00, 2'd0, 1'b1);
        chk("acc8_ovf_held", ovf8, 1'b1);
        chk("acc8_ready", ready8, 1'b1);
        chk("acc8_err", err8, 1'b0);
        chk("acc8_drop", drop8, 1'b0);
        chk("acc16_ovf", ovf, 1'b0);

        // Reset during the second result word
        send4(2'd0, 8'hF0, 8'hF0, 8'hF0, 8'h30, 1'b1);
        cycle(1'b0, 8'h00, 2'd0, 1'b1);
        chk("pre_reset_hi", txd, 8'h03);
        set_reset(1'b1);
        #1;
        chk("rst_txv", txv, 1'b0);
        chk("rst_txd", txd, 8'h00);
        chk("rst_ready", ready, 1'b0);
        chk("rst_done", done, 1'b0);
        cycle(1'b0, 8'h00, 2'd0, 1'b1);
        set_reset(1'b0);
        #1 chk("rel_ready", ready, 1'b1);
        send4(2'd0, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
        chk("post_reset_sum", txd, 8'h0A);

        // Randomized traffic: alternating dense and sparse input phases
        for (int i = 0; i < 2400; i++) begin
            pct = ((i / 200) % 2 == 0) ? 70 : 12;
            if ($urandom_range(0, 399) == 0) begin
                set_reset(1'b1);
                cycle(1'b0, 8'h00, 2'd0, 1'b0);
                set_reset(1'b0);
            end
            cycle($urandom_range(0, 99) < pct, 8'($urandom_range(0, 255)),
                  2'($urandom_range(0, 3)), $urandom_range(0, 99) < 60);
        end
        repeat (4) cycle(1'b0, 8'h00, 2'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
